grf_wb: RTL and testbench

- Writeback-side consumer of the W-stage pipeline register.
- Holds the 32x32 general register file and commits the W-stage write {A3W, WDW} each cycle.
- Serves two combinational read ports to the D stage, with internal write-to-read bypass.
- Records every committed write as a {PC, reg, data} trace entry in a small show-ahead FIFO, drained by the debug/trace reader over a valid/ready handshake.

---
 rtl/grf_wb_pkg.sv | 24 ++
 rtl/grf_wb_if.sv | 24 ++
 rtl/grf_wb_trace_fifo.sv | 56 +++++
 rtl/grf_wb.sv | 83 ++++++++
 tb/tb_grf_wb.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the writeback register file and its trace path.
package grf_wb_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RAW     = 5;
  localparam int unsigned TRACE_W = 69;

  localparam logic [RAW-1:0] REG_ZERO = 5'd0;

  // Trace entry field offsets: {PC, A3, WD}
  localparam int unsigned TR_PC_MSB = 68;
  localparam int unsigned TR_PC_LSB = 37;
  localparam int unsigned TR_A3_MSB = 36;
  localparam int unsigned TR_A3_LSB = 32;
  localparam int unsigned TR_WD_MSB = 31;
  localparam int unsigned TR_WD_LSB = 0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RAW-1:0]  a3;
    logic [XLEN-1:0] wd;
  } trace_entry_t;

endpackage

// File: rtl/grf_wb_if.sv
// Trace read-out bus between the register file and the debug/trace reader.
interface grf_wb_if #(
  parameter int unsigned TRACE_AW = 3
) ();

  logic              TrValid;
  logic              TrReady;
  logic [31:0]       TrPC;
  logic [4:0]        TrA3;
  logic [31:0]       TrWD;
  logic [TRACE_AW:0] TrCount;
  logic              TrOverflow;

  modport master (
    output TrValid, TrPC, TrA3, TrWD, TrCount, TrOverflow,
    input  TrReady
  );

  modport slave (
    input  TrValid, TrPC, TrA3, TrWD, TrCount, TrOverflow,
    output TrReady
  );

endinterface

// File: rtl/grf_wb_trace_fifo.sv
// Show-ahead FIFO: head is visible while non-empty, zero when empty; drops on full.
module grf_wb_trace_fifo #(
  parameter int unsigned W     = 69,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/grf_wb.sv
// W-stage register file with same-cycle write bypass and a commit trace FIFO.
module grf_wb
  import grf_wb_pkg::*;
#(
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned TRACE_AW    = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  A3W,
  input  logic [31:0] WDW,
  input  logic [31:0] PCW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  grf_wb_if.master    tr
);

  logic [XLEN-1:0]    regs [32];
  logic               commit;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [TRACE_W-1:0] fifo_din;
  logic [TRACE_W-1:0] fifo_dout;
  trace_entry_t       entry;

  assign commit = (A3W != REG_ZERO);

  // Register storage; entry 0 is never written and never read out
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[A3W] <= WDW;
    end
  end

  // Read ports: zero register, then the in-flight write, then storage
  always_comb begin
    RD1 = regs[A1];
    RD2 = regs[A2];
    if (commit && A1 == A3W) RD1 = WDW;
    if (commit && A2 == A3W) RD2 = WDW;
    if (A1 == REG_ZERO)      RD1 = '0;
    if (A2 == REG_ZERO)      RD2 = '0;
  end

  // Pack the committed write as a trace entry
  always_comb begin
    entry    = '{pc: PCW, a3: A3W, wd: WDW};
    fifo_din = TRACE_W'(entry);
  end

  assign pop = tr.TrValid & tr.TrReady;

  grf_wb_trace_fifo #(
    .W     (TRACE_W),
    .DEPTH (TRACE_DEPTH),
    .AW    (TRACE_AW)
  ) u_trace_fifo (
    .clk      (Clk),
    .rst_n    (Reset),
    .push     (commit),
    .pop      (pop),
    .din      (fifo_din),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (tr.TrCount),
    .overflow (tr.TrOverflow)
  );

  assign tr.TrValid = ~fifo_empty;
  assign tr.TrPC    = fifo_dout[TR_PC_MSB:TR_PC_LSB];
  assign tr.TrA3    = fifo_dout[TR_A3_MSB:TR_A3_LSB];
  assign tr.TrWD    = fifo_dout[TR_WD_MSB:TR_WD_LSB];

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_grf_wb.sv
// Randomized self-checking bench for grf_wb against a queue-based reference model.
module tb_grf_wb;

  localparam int DEPTH = 8;

  logic        Clk;
  logic        Reset;
  logic [4:0]  A3W;
  logic [31:0] WDW;
  logic [31:0] PCW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;

  grf_wb_if #(.TRACE_AW(3)) tr ();

  grf_wb #(.TRACE_DEPTH(8), .TRACE_AW(3)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .A3W   (A3W),
    .WDW   (WDW),
    .PCW   (PCW),
    .A1    (A1),
    .A2    (A2),
    .RD1   (RD1),
    .RD2   (RD2),
    .tr    (tr)
  );

  initial begin
    Clk = 1'b0;
    forever #50 Clk = ~Clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a3;
    logic [31:0] wd;
  } ent_t;

  logic [31:0] mregs [32];
  ent_t        mq [$];
  logic        movf;

  int tests_run;
  int tests_failed;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mq.delete();
    movf = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (A3W != 5'd0 && a == A3W) return WDW;
    return mregs[a];
  endfunction

  function automatic ent_t exp_head();
    ent_t e;
    e.pc = '0; e.a3 = '0; e.wd = '0;
    if (mq.size() != 0) e = mq[0];
    return e;
  endfunction

  // Advance one clock, applying the commit/trace rules to the model
  task automatic cycle();
    bit   push_b, pop_b, full_b;
    ent_t e;
    push_b = (A3W != 5'd0);
    pop_b  = (mq.size() != 0) && tr.TrReady;
    full_b = (mq.size() == DEPTH);
    e.pc = PCW; e.a3 = A3W; e.wd = WDW;
    @(posedge Clk);
    if (push_b) mregs[A3W] = WDW;
    if (pop_b) mq.delete(0);
    if (push_b) begin
      if (!full_b || pop_b) mq.push_back(e);
      else movf = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    A3W = '0; WDW = '0; PCW = '0; A1 = '0; A2 = '0; tr.TrReady = 1'b0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #2;
    model_reset();
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    idle_inputs();
    A1 = 5'd7;
    #2;
    model_reset();
    tests_run++;
    if (tr.TrValid !== 1'b0 || tr.TrCount !== 4'd0 || tr.TrOverflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: valid=%b count=%0d ovf=%b, expected 0/0/0", tr.TrValid, tr.TrCount, tr.TrOverflow);
    end
    tests_run++;
    if (tr.TrPC !== 32'd0 || tr.TrA3 !== 5'd0 || tr.TrWD !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_head: pc=%h a3=%0d wd=%h, expected zeros", tr.TrPC, tr.TrA3, tr.TrWD);
    end
    tests_run++;
    if (RD1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_rd1: got %h expected 0", RD1);
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_bypass();
    A3W = 5'd5; WDW = 32'hDEADBEEF; PCW = 32'h3000; A1 = 5'd5; A2 = 5'd0;
    #1;
    tests_run++;
    if (RD1 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL bypass_rd1: got %h expected deadbeef", RD1);
    end
    tests_run++;
    if (tr.TrValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_no_fallthrough: valid=%b expected 0", tr.TrValid);
    end
    cycle();
    A3W = 5'd0; WDW = 32'h0;
    #1;
    tests_run++;
    if (RD1 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL stored_rd1: got %h expected deadbeef", RD1);
    end
    tests_run++;
    if (tr.TrValid !== 1'b1 || tr.TrPC !== 32'h3000 || tr.TrA3 !== 5'd5 || tr.TrWD !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL bypass_trace: valid=%b pc=%h a3=%0d wd=%h expected 1/3000/5/deadbeef",
               tr.TrValid, tr.TrPC, tr.TrA3, tr.TrWD);
    end
  endtask

  task automatic test_no_commit();
    tr.TrReady = 1'b1;
    cycle();
    tr.TrReady = 1'b0;
    A3W = 5'd0; WDW = 32'hFFFFFFFF; PCW = 32'h4000; A1 = 5'd0; A2 = 5'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (RD1 !== 32'd0 || RD2 !== 32'd0 || tr.TrCount !== 4'd0 || tr.TrValid !== 1'b0) begin
        tests_failed++;
        $display("FAIL no_commit[%0d]: rd1=%h rd2=%h count=%0d valid=%b expected 0/0/0/0",
                 k, RD1, RD2, tr.TrCount, tr.TrValid);
      end
      cycle();
    end
    A1 = 5'd5;
    #1;
    tests_run++;
    if (RD1 !== mregs[5]) begin
      tests_failed++;
      $display("FAIL no_commit_reg5: got %h expected %h", RD1, mregs[5]);
    end
  endtask

  task automatic test_overflow();
    ent_t h;
    pulse_reset();
    tr.TrReady = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      A3W = 5'(r); WDW = $urandom; PCW = 32'h1000 + 32'(4 * r);
      cycle();
    end
    A3W = 5'd0;
    #1;
    tests_run++;
    if (tr.TrCount !== 4'd8 || tr.TrOverflow !== 1'b1 || movf !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_flags: count=%0d ovf=%b expected 8/1", tr.TrCount, tr.TrOverflow);
    end
    tr.TrReady = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      #1;
      h = exp_head();
      tests_run++;
      if (tr.TrA3 !== 5'(r) || tr.TrWD !== h.wd || tr.TrPC !== h.pc) begin
        tests_failed++;
        $display("FAIL overflow_drain[%0d]: a3=%0d wd=%h pc=%h expected %0d/%h/%h",
                 r, tr.TrA3, tr.TrWD, tr.TrPC, r, h.wd, h.pc);
      end
      cycle();
    end
    tr.TrReady = 1'b0;
    A1 = 5'd9;
    #1;
    tests_run++;
    if (tr.TrValid !== 1'b0 || RD1 !== mregs[9]) begin
      tests_failed++;
      $display("FAIL overflow_reg9: valid=%b rd1=%h expected 0/%h", tr.TrValid, RD1, mregs[9]);
    end
  endtask

  task automatic test_full_push_pop();
    ent_t h;
    pulse_reset();
    tr.TrReady = 1'b0;
    for (int r = 11; r <= 18; r++) begin
      A3W = 5'(r); WDW = $urandom; PCW = 32'h2000 + 32'(4 * r);
      cycle();
    end
    A3W = 5'd10; WDW = $urandom; PCW = 32'h2ABC; tr.TrReady = 1'b1;
    cycle();
    A3W = 5'd0;
    #1;
    tests_run++;
    if (tr.TrCount !== 4'd8 || tr.TrOverflow !== 1'b0 || tr.TrA3 !== 5'd12) begin
      tests_failed++;
      $display("FAIL full_push_pop: count=%0d ovf=%b head_a3=%0d expected 8/0/12",
               tr.TrCount, tr.TrOverflow, tr.TrA3);
    end
    for (int k = 0; k < 8; k++) begin
      #1;
      h = exp_head();
      tests_run++;
      if (tr.TrValid !== 1'b1 || tr.TrA3 !== h.a3 || tr.TrWD !== h.wd || tr.TrPC !== h.pc) begin
        tests_failed++;
        $display("FAIL full_drain[%0d]: a3=%0d wd=%h pc=%h expected %0d/%h/%h",
                 k, tr.TrA3, tr.TrWD, tr.TrPC, h.a3, h.wd, h.pc);
      end
      if (k == 7) begin
        tests_run++;
        if (tr.TrA3 !== 5'd10 || tr.TrPC !== 32'h2ABC) begin
          tests_failed++;
          $display("FAIL full_tail: a3=%0d pc=%h expected 10/2abc", tr.TrA3, tr.TrPC);
        end
      end
      cycle();
    end
    tr.TrReady = 1'b0;
  endtask

  task automatic test_wrap_random();
    ent_t h;
    tr.TrReady = 1'b0;
    for (int k = 0; k < 20; k++) begin
      A3W = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      WDW = $urandom; PCW = $urandom;
      A1 = ($urandom_range(0, 1) == 0) ? A3W : 5'($urandom_range(0, 31));
      A2 = 5'($urandom_range(0, 31));
      tr.TrReady = ~tr.TrReady;
      #1;
      h = exp_head();
      tests_run++;
      if (RD1 !== exp_rd(A1) || RD2 !== exp_rd(A2)) begin
        tests_failed++;
        $display("FAIL wrap_rd[%0d]: rd1=%h rd2=%h expected %h/%h", k, RD1, RD2, exp_rd(A1), exp_rd(A2));
      end
      tests_run++;
      if (tr.TrValid !== (mq.size() != 0) || tr.TrCount !== 4'(mq.size()) ||
          tr.TrA3 !== h.a3 || tr.TrWD !== h.wd || tr.TrPC !== h.pc) begin
        tests_failed++;
        $display("FAIL wrap_trace[%0d]: valid=%b count=%0d a3=%0d wd=%h expected %0d entries head %0d/%h",
                 k, tr.TrValid, tr.TrCount, tr.TrA3, tr.TrWD, mq.size(), h.a3, h.wd);
      end
      cycle();
    end
    A3W = 5'd0; tr.TrReady = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      #1;
      h = exp_head();
      tests_run++;
      if (tr.TrValid !== (mq.size() != 0) || tr.TrA3 !== h.a3 || tr.TrWD !== h.wd || tr.TrPC !== h.pc) begin
        tests_failed++;
        $display("FAIL wrap_drain[%0d]: valid=%b a3=%0d wd=%h expected %0d/%h",
                 k, tr.TrValid, tr.TrA3, tr.TrWD, h.a3, h.wd);
      end
      cycle();
    end
    tr.TrReady = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int bad;
    tr.TrReady = 1'b0;
    for (int r = 20; r < 24; r++) begin
      A3W = 5'(r); WDW = $urandom | 32'h1; PCW = $urandom;
      cycle();
    end
    A3W = 5'd0;
    #1;
    tests_run++;
    if (tr.TrCount !== 4'd4) begin
      tests_failed++;
      $display("FAIL midstream_queued: count=%0d expected 4", tr.TrCount);
    end
    Reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (tr.TrValid !== 1'b0 || tr.TrCount !== 4'd0 || tr.TrA3 !== 5'd0) begin
      tests_failed++;
      $display("FAIL midstream_trace: valid=%b count=%0d a3=%0d expected 0/0/0", tr.TrValid, tr.TrCount, tr.TrA3);
    end
    bad = 0;
    for (int a = 1; a < 32; a++) begin
      A1 = 5'(a);
      #1;
      if (RD1 !== 32'd0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL midstream_regs: %0d nonzero registers, expected 0", bad);
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    test_reset();
    test_bypass();
    test_no_commit();
    test_overflow();
    test_full_push_pop();
    test_wrap_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
